// File: rtl/tpu_writeback.sv
// tpu_writeback: quantises one row of accumulator lanes per accepted beat and
// streams it into NUM_BANKS output SRAM banks through a 1-deep output register.
// Ports:
//   clk, srstn           clock, synchronous active-low reset
//   i_start              job start pulse (latches i_shift_amt, i_round_en)
//   i_in_valid/o_in_ready, i_in_data, i_in_last   row handshake from the array
//   i_wr_hold            SRAM busy, suppresses the write of the held row
//   o_sram_write_enable  one-hot bank enable, o_sram_waddr/o_sram_wdata shared
//   o_busy, o_done       job in progress / last row written pulse
//   o_sat_count          rows in the job with at least one saturated lane
module tpu_writeback #(
  parameter int unsigned ARRAY_SIZE        = 32,
  parameter int unsigned ORI_WIDTH         = 21,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned NUM_BANKS         = 3,
  parameter int unsigned ADDR_WIDTH        = 6,
  parameter int unsigned ROWS_PER_BANK     = 32,
  parameter int unsigned SHIFT_WIDTH       = 5
) (
  input  logic                                  clk,
  input  logic                                  srstn,
  input  logic                                  i_start,
  input  logic [SHIFT_WIDTH-1:0]                i_shift_amt,
  input  logic                                  i_round_en,
  input  logic                                  i_in_valid,
  output logic                                  o_in_ready,
  input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]       i_in_data,
  input  logic                                  i_in_last,
  input  logic                                  i_wr_hold,
  output logic [NUM_BANKS-1:0]                  o_sram_write_enable,
  output logic [ADDR_WIDTH-1:0]                 o_sram_waddr,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] o_sram_wdata,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [15:0]                           o_sat_count
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned EXT_W  = ORI_WIDTH + 1;
  localparam int unsigned DATA_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam logic signed [EXT_W-1:0] L_MAX = EXT_W'(2**(OUTPUT_DATA_WIDTH-1) - 1);
  localparam logic signed [EXT_W-1:0] L_MIN = ~L_MAX;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   r_state, w_state_nxt;
  logic [SHIFT_WIDTH-1:0]   r_shift;
  logic                     r_round;
  logic [BANK_W-1:0]        r_bank;
  logic [ADDR_WIDTH-1:0]    r_row;
  logic                     r_pend;
  logic [BANK_W-1:0]        r_tag_bank;
  logic                     r_tag_last;
  logic                     r_last_acc;
  logic [ADDR_WIDTH-1:0]    r_waddr;
  logic [DATA_W-1:0]        r_wdata;
  logic [15:0]              r_sat_count;

  logic                     w_write;
  logic                     w_accept;
  logic [DATA_W-1:0]        w_q;
  logic [ARRAY_SIZE-1:0]    w_sat;

  // Handshake and write strobes; the write reacts to i_wr_hold in the same cycle.
  assign o_in_ready = (r_state == S_RUN) && !r_last_acc && (!r_pend || !i_wr_hold);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_write    = r_pend && !i_wr_hold;

  assign o_sram_write_enable = w_write ? (NUM_BANKS'(1) << r_tag_bank) : '0;
  assign o_sram_waddr        = r_waddr;
  assign o_sram_wdata        = r_wdata;
  assign o_busy              = (r_state == S_RUN);
  assign o_done              = w_write && r_tag_last;
  assign o_sat_count         = r_sat_count;

  // Per-lane round, arithmetic shift and saturate using the job's latched shift.
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    logic signed [EXT_W-1:0] w_ext, w_rnd, w_sum, w_shr;
    logic                    w_hi, w_lo;
    assign w_ext = {i_in_data[g*ORI_WIDTH + ORI_WIDTH - 1], i_in_data[g*ORI_WIDTH +: ORI_WIDTH]};
    assign w_rnd = (r_round && (r_shift != '0)) ? (EXT_W'(1) << (r_shift - SHIFT_WIDTH'(1))) : '0;
    assign w_sum = w_ext + w_rnd;
    assign w_shr = w_sum >>> r_shift;
    assign w_hi  = (w_shr > L_MAX);
    assign w_lo  = (w_shr < L_MIN);
    assign w_sat[g] = w_hi || w_lo;
    assign w_q[g*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
      w_hi ? L_MAX[OUTPUT_DATA_WIDTH-1:0] :
      w_lo ? L_MIN[OUTPUT_DATA_WIDTH-1:0] : w_shr[OUTPUT_DATA_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: job ends when the last-tagged row is actually written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_write && r_tag_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job setup, output register and bank/row addressing.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_shift     <= '0;
      r_round     <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_pend      <= 1'b0;
      r_tag_bank  <= '0;
      r_tag_last  <= 1'b0;
      r_last_acc  <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_sat_count <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_shift     <= i_shift_amt;
        r_round     <= i_round_en;
        r_bank      <= '0;
        r_row       <= '0;
        r_last_acc  <= 1'b0;
        r_sat_count <= '0;
      end
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_wdata    <= w_q;
        r_waddr    <= r_row;
        r_tag_bank <= r_bank;
        r_tag_last <= i_in_last;
        if (i_in_last) r_last_acc <= 1'b1;
        if (r_row == ADDR_WIDTH'(ROWS_PER_BANK - 1)) begin
          r_row  <= '0;
          r_bank <= (r_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_bank + BANK_W'(1);
        end else begin
          r_row <= r_row + ADDR_WIDTH'(1);
        end
        if ((|w_sat) && (r_sat_count != 16'hFFFF)) r_sat_count <= r_sat_count + 16'd1;
      end else if (w_write) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_writeback.sv
module tb_tpu_writeback;
  localparam int AS  = 4;
  localparam int ORI = 21;
  localparam int OW  = 16;
  localparam int NB  = 3;
  localparam int AW  = 6;
  localparam int RPB = 4;
  localparam int SW  = 5;
  localparam int IW  = AS * ORI;
  localparam int DW  = AS * OW;

  logic           clk = 1'b0;
  logic           srstn, start, round_en, in_valid, in_ready, in_last, wr_hold;
  logic [SW-1:0]  shift_amt;
  logic [IW-1:0]  in_data;
  logic [NB-1:0]  sram_write_enable;
  logic [AW-1:0]  sram_waddr;
  logic [DW-1:0]  sram_wdata;
  logic           busy, done;
  logic [15:0]    sat_count;

  tpu_writeback #(
    .ARRAY_SIZE(AS), .ORI_WIDTH(ORI), .OUTPUT_DATA_WIDTH(OW), .NUM_BANKS(NB),
    .ADDR_WIDTH(AW), .ROWS_PER_BANK(RPB), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .srstn(srstn), .i_start(start), .i_shift_amt(shift_amt),
    .i_round_en(round_en), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_last(in_last), .i_wr_hold(wr_hold),
    .o_sram_write_enable(sram_write_enable), .o_sram_waddr(sram_waddr),
    .o_sram_wdata(sram_wdata), .o_busy(busy), .o_done(done), .o_sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_writes = 0;

  // Reference model: job-level view (rows accepted so far, one pending write).
  bit            m_run, m_last_acc, m_pend, m_pend_last, m_round, m_acc;
  int            m_n, m_shift, m_sat, m_pend_bank, m_pend_addr;
  logic [DW-1:0] m_pend_data;
  logic [IW-1:0] job_rows[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] quant(input logic [ORI-1:0] lane, input int s,
                                          input bit r, output bit sat);
    longint v;
    v = longint'($signed(lane));
    if (r && s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    sat = 1'b0;
    if (v > 32767) begin v = 32767; sat = 1'b1; end
    else if (v < -32768) begin v = -32768; sat = 1'b1; end
    return OW'(v);
  endfunction

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] row;
    int x;
    for (int i = 0; i < AS; i++) begin
      case ($urandom % 3)
        0: x = int'($urandom_range(0, 400)) - 200;
        1: x = int'($urandom_range(0, 80000)) - 40000;
        default: x = int'($urandom);
      endcase
      row[i*ORI +: ORI] = ORI'(x);
    end
    return row;
  endfunction

  function automatic logic [IW-1:0] mk_row(input int l0, input int l1, input int l2, input int l3);
    logic [IW-1:0] row;
    row[0*ORI +: ORI] = ORI'(l0);
    row[1*ORI +: ORI] = ORI'(l1);
    row[2*ORI +: ORI] = ORI'(l2);
    row[3*ORI +: ORI] = ORI'(l3);
    return row;
  endfunction

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic step(input bit st, input int sh, input bit rnd, input bit v,
                      input logic [IW-1:0] d, input bit l, input bit h, input bit rst);
    bit exp_rdy, wr, fin, any_sat, s;
    logic [NB-1:0] exp_we;
    logic [DW-1:0] qd;
    @(negedge clk);
    srstn = !rst; start = st; shift_amt = SW'(sh); round_en = rnd;
    in_valid = v; in_data = d; in_last = l; wr_hold = h;
    #1;
    exp_rdy = m_run && !m_last_acc && (!m_pend || !h);
    wr      = m_pend && !h;
    fin     = wr && m_pend_last;
    exp_we  = wr ? (NB'(1) << m_pend_bank) : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("write_enable", 64'(sram_write_enable), 64'(exp_we));
    chk("done", 64'(done), 64'(fin));
    chk("busy", 64'(busy), 64'(m_run));
    chk("sat_count", 64'(sat_count), 64'(m_sat));
    if (m_pend) begin
      chk("waddr", 64'(sram_waddr), 64'(m_pend_addr));
      chk("wdata", 64'(sram_wdata), 64'(m_pend_data));
    end
    if (|sram_write_enable) dut_writes++;
    m_acc = 1'b0;
    if (rst) begin
      m_run = 0; m_pend = 0; m_sat = 0; m_last_acc = 0; m_n = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_shift = sh; m_round = rnd; m_n = 0; m_sat = 0; m_last_acc = 0;
      end
    end else begin
      m_acc = v && exp_rdy;
      if (m_acc) begin
        any_sat = 0;
        for (int i = 0; i < AS; i++) begin
          qd[i*OW +: OW] = quant(d[i*ORI +: ORI], m_shift, m_round, s);
          any_sat |= s;
        end
        m_pend = 1; m_pend_data = qd; m_pend_last = l;
        m_pend_bank = (m_n / RPB) % NB;
        m_pend_addr = m_n % RPB;
        m_n++;
        if (any_sat && m_sat < 65535) m_sat++;
        if (l) m_last_acc = 1;
      end else if (wr) begin
        m_pend = 0;
      end
      if (fin) m_run = 0;
    end
    @(posedge clk);
  endtask

  // hold_mode: 0 none, 1 random, 2 three-cycle hold after the first row.
  task automatic run_job(input int sh, input bit rnd, input int hold_mode, input int rst_at);
    int len, idx, cyc;
    bit v, h, st;
    len = job_rows.size();
    idx = 0; cyc = 0;
    step(1'b1, sh, rnd, 1'($urandom % 2), job_rows[0], 1'b0, 1'b0, 1'b0);
    while (m_run && cyc < 400) begin
      if (rst_at >= 0 && idx == rst_at) begin
        step(1'b0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        break;
      end
      v  = (idx < len) && (hold_mode != 1 || ($urandom % 4 != 0));
      h  = (hold_mode == 1) ? ($urandom % 3 == 0) : (hold_mode == 2) ? (cyc >= 1 && cyc <= 3) : 1'b0;
      st = (hold_mode == 1) && ($urandom % 8 == 0);
      step(st, int'($urandom_range(0, ORI - 1)), 1'($urandom % 2), v,
           job_rows[(idx < len) ? idx : 0], (idx == len - 1), h, 1'b0);
      if (m_acc) idx++;
      cyc++;
    end
    chk("job_not_finished", 64'(m_run), 64'(0));
  endtask

  initial begin
    m_run = 0; m_pend = 0; m_sat = 0; m_last_acc = 0; m_n = 0; m_acc = 0;
    m_pend_last = 0; m_shift = 0; m_round = 0; m_pend_bank = 0; m_pend_addr = 0; m_pend_data = '0;
    srstn = 0; start = 0; shift_amt = '0; round_en = 0; in_valid = 0;
    in_data = '0; in_last = 0; wr_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_we", 64'(sram_write_enable), 0);
    chk("rst_waddr", 64'(sram_waddr), 0);
    chk("rst_wdata", 64'(sram_wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_sat", 64'(sat_count), 0);

    // Streaming: 12 back-to-back rows across all three banks.
    job_rows.delete();
    for (int i = 0; i < 12; i++) job_rows.push_back(rand_row());
    dut_writes = 0;
    run_job(3, 1'b0, 0, -1);
    chk("stream_writes", 64'(dut_writes), 64'd12);

    // Quantisation with rounding.
    job_rows.delete();
    job_rows.push_back(mk_row(24, -24, 0, 1000));
    run_job(4, 1'b1, 0, -1);
    chk("q_round_pos", 64'(sram_wdata[15:0]), 64'h0002);
    chk("q_round_neg", 64'(sram_wdata[31:16]), 64'hFFFF);

    job_rows.delete();
    job_rows.push_back(mk_row(24, -24, 0, 0));
    run_job(4, 1'b0, 0, -1);
    chk("q_trunc_neg", 64'(sram_wdata[31:16]), 64'hFFFE);
    chk("q_no_sat", 64'(sat_count), 64'd0);

    // Saturation.
    job_rows.delete();
    job_rows.push_back(mk_row(40000, -40000, 5, -5));
    run_job(0, 1'b0, 0, -1);
    chk("sat_hi", 64'(sram_wdata[15:0]), 64'h7FFF);
    chk("sat_lo", 64'(sram_wdata[31:16]), 64'h8000);
    chk("sat_count_1", 64'(sat_count), 64'd1);

    // Three-cycle write hold.
    job_rows.delete();
    for (int i = 0; i < 6; i++) job_rows.push_back(rand_row());
    dut_writes = 0;
    run_job(2, 1'b1, 2, -1);
    chk("hold_writes", 64'(dut_writes), 64'd6);

    // Reset after 5 of 10 rows, then idle and restart.
    job_rows.delete();
    for (int i = 0; i < 10; i++) job_rows.push_back(rand_row());
    run_job(1, 1'b0, 0, 5);
    #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_wdata", 64'(sram_wdata), 0);
    dut_writes = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    chk("midrst_no_writes", 64'(dut_writes), 0);
    job_rows.delete();
    for (int i = 0; i < 14; i++) job_rows.push_back(rand_row());
    run_job(5, 1'b1, 0, -1);

    // Randomised jobs with random hold, gaps and stray starts.
    for (int j = 0; j < 25; j++) begin
      job_rows.delete();
      for (int i = 0; i < int'($urandom_range(1, 14)); i++) job_rows.push_back(rand_row());
      run_job(int'($urandom_range(0, ORI - 1)), 1'($urandom % 2), 1, -1);
      if ($urandom % 2 == 1) step(1'b0, 0, 1'b0, 1'b1, rand_row(), 1'b1, 1'($urandom % 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
